// File: rtl/smith_waterman_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | smith_waterman_pkg : shared types for the Smith-Waterman host blocks |
// | rev 1.0                                                              |
// +--------------------------------------------------------------------+
package smith_waterman_pkg;

  localparam int HC_ADDR_W = 42;
  localparam int RD_DEPTH  = 32;

  typedef logic [HC_ADDR_W-1:0] t_hc_address;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_RUN  = 2'd1,
    RD_DONE = 2'd2
  } t_rd_state;

endpackage
`default_nettype wire

// File: rtl/smith_waterman_rob.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | smith_waterman_rob : tag-indexed reorder buffer for read responses  |
// | rev 1.0                                                              |
// +--------------------------------------------------------------------+
module smith_waterman_rob
  import smith_waterman_pkg::*;
#(
  parameter int DEPTH  = RD_DEPTH,
  parameter int DATA_W = 512,
  parameter int TAG_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [TAG_W-1:0]  rd_tag,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              clr_en
);

  logic [DEPTH-1:0]  valid;
  logic [DATA_W-1:0] mem [DEPTH];

  assign rd_valid = valid[rd_tag];
  assign rd_data  = mem[rd_tag];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_tag] <= wr_data;
  end

  // Write is applied after clear so a fill never gets lost to a same-cycle pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= '0;
    end else begin
      assert (!(wr_en && valid[wr_tag]));
      if (clr_en) valid[rd_tag] <= 1'b0;
      if (wr_en)  valid[wr_tag] <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/smith_waterman_rd_engine.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | smith_waterman_rd_engine : CCI-P c0 line reader with in-order output |
// | rev 1.0                                                              |
// +--------------------------------------------------------------------+
module smith_waterman_rd_engine
  import smith_waterman_pkg::*;
#(
  parameter int ADDR_W = $bits(t_hc_address),
  parameter int DATA_W = 512,
  parameter int SIZE_W = 32,
  parameter int DEPTH  = RD_DEPTH,
  parameter int TAG_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [SIZE_W-1:0] num_lines,
  output logic              rd_req_valid,
  output logic [ADDR_W-1:0] rd_req_addr,
  output logic [15:0]       rd_req_mdata,
  input  logic              rd_req_almfull,
  input  logic              rd_rsp_valid,
  input  logic [15:0]       rd_rsp_mdata,
  input  logic [DATA_W-1:0] rd_rsp_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  t_rd_state         state;
  logic [ADDR_W-1:0] base_r;
  logic [SIZE_W-1:0] lines_r;
  logic [SIZE_W-1:0] issued;
  logic [SIZE_W-1:0] drained;
  logic [SIZE_W:0]   in_flight;
  logic [SIZE_W-1:0] next_line;
  logic              fire;
  logic              can_issue;
  logic              rsp_wr;
  logic              head_valid;
  logic              load;
  logic [DATA_W-1:0] head_data;
  logic              unused_ok;

  assign fire      = out_valid & out_ready;
  assign in_flight = {1'b0, issued} - {1'b0, drained};
  assign can_issue = (state == RD_RUN) && (issued < lines_r) && !rd_req_almfull &&
                     (in_flight < (SIZE_W+1)'(DEPTH));
  assign rsp_wr    = (state == RD_RUN) && rd_rsp_valid;
  // The output register pops the line after the one being handed off, giving 1 line/cycle.
  assign next_line = fire ? drained + 1'b1 : drained;
  assign load      = (state == RD_RUN) && (!out_valid || fire) && head_valid;
  assign unused_ok = ^rd_rsp_mdata[15:TAG_W];

  smith_waterman_rob #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .TAG_W  (TAG_W)
  ) u_rob (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (rsp_wr),
    .wr_tag   (rd_rsp_mdata[TAG_W-1:0]),
    .wr_data  (rd_rsp_data),
    .rd_tag   (next_line[TAG_W-1:0]),
    .rd_valid (head_valid),
    .rd_data  (head_data),
    .clr_en   (load)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= RD_IDLE;
      base_r       <= '0;
      lines_r      <= '0;
      issued       <= '0;
      drained      <= '0;
      rd_req_valid <= 1'b0;
      rd_req_addr  <= '0;
      rd_req_mdata <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_last     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      case (state)
        RD_IDLE, RD_DONE: begin
          if (start) begin
            base_r  <= base_addr;
            lines_r <= num_lines;
            issued  <= '0;
            drained <= '0;
            state   <= (num_lines == '0) ? RD_DONE : RD_RUN;
            busy    <= (num_lines != '0);
            done    <= (num_lines == '0);
          end
        end
        RD_RUN: begin
          if (fire && out_last) begin
            state <= RD_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= RD_IDLE;
      endcase

      rd_req_valid <= can_issue;
      if (can_issue) begin
        rd_req_addr  <= base_r + ADDR_W'(issued);
        rd_req_mdata <= 16'(issued[TAG_W-1:0]);
        issued       <= issued + 1'b1;
      end

      if (fire) drained <= drained + 1'b1;

      if (load) begin
        out_valid <= 1'b1;
        out_data  <= head_data;
        out_last  <= (next_line == lines_r - 1'b1);
      end else if (fire) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_smith_waterman_rd_engine.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_smith_waterman_rd_engine : directed/random bench with line model  |
// | rev 1.0                                                              |
// +--------------------------------------------------------------------+
module tb_smith_waterman_rd_engine;

  localparam int ADDR_W = 42;
  localparam int DATA_W = 512;
  localparam int SIZE_W = 32;
  localparam int DEPTH  = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [SIZE_W-1:0] num_lines;
  logic              rd_req_valid;
  logic [ADDR_W-1:0] rd_req_addr;
  logic [15:0]       rd_req_mdata;
  logic              rd_req_almfull;
  logic              rd_rsp_valid;
  logic [15:0]       rd_rsp_mdata;
  logic [DATA_W-1:0] rd_rsp_data;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              out_ready;
  logic              busy;
  logic              done;

  always #5 clk = ~clk;

  smith_waterman_rd_engine dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .base_addr      (base_addr),
    .num_lines      (num_lines),
    .rd_req_valid   (rd_req_valid),
    .rd_req_addr    (rd_req_addr),
    .rd_req_mdata   (rd_req_mdata),
    .rd_req_almfull (rd_req_almfull),
    .rd_rsp_valid   (rd_rsp_valid),
    .rd_rsp_mdata   (rd_rsp_mdata),
    .rd_rsp_data    (rd_rsp_data),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_last       (out_last),
    .out_ready      (out_ready),
    .busy           (busy),
    .done           (done)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Host memory model: every requested line gets a random payload on first touch.
  logic [DATA_W-1:0] mem [logic [ADDR_W-1:0]];
  logic [ADDR_W-1:0] req_addr_q [$];
  logic [15:0]       req_tag_q  [$];
  logic [ADDR_W-1:0] pend_addr  [$];
  logic [15:0]       pend_tag   [$];
  int                pend_cyc   [$];
  logic [DATA_W-1:0] beat_q     [$];
  logic              last_q     [$];

  int                rsp_mode;    // 0 in-order latency 10, 1 random order, 2 withhold
  int                ready_mode;  // 0 always, 1 random, 2 toggle
  int                almfull_viol;
  int                stall_viol;
  logic              af_last;
  logic              held;
  logic [DATA_W-1:0] held_data;

  task automatic chk(input string name, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] rand_line();
    logic [DATA_W-1:0] v;
    for (int i = 0; i < DATA_W/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic step();
    if (held && !(out_valid && out_data === held_data)) stall_viol++;
    held      = out_valid && !out_ready;
    held_data = out_data;
    if (af_last && rd_req_valid) almfull_viol++;
    af_last = rd_req_almfull;
    if (rd_req_valid) begin
      req_addr_q.push_back(rd_req_addr);
      req_tag_q.push_back(rd_req_mdata);
      if (!mem.exists(rd_req_addr)) mem[rd_req_addr] = rand_line();
      pend_addr.push_back(rd_req_addr);
      pend_tag.push_back(rd_req_mdata);
      pend_cyc.push_back(cyc);
    end
    if (out_valid && out_ready) begin
      beat_q.push_back(out_data);
      last_q.push_back(out_last);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send_idx(input int k);
    rd_rsp_valid = 1'b1;
    rd_rsp_mdata = pend_tag[k];
    rd_rsp_data  = mem[pend_addr[k]];
    pend_addr.delete(k);
    pend_tag.delete(k);
    pend_cyc.delete(k);
  endtask

  task automatic tick();
    int k = -1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      2:       out_ready = ~out_ready;
      default: out_ready = 1'b0;
    endcase
    if (pend_addr.size() > 0) begin
      if (rsp_mode == 0 && cyc >= pend_cyc[0] + 10) k = 0;
      else if (rsp_mode == 1 && $urandom_range(0, 1) == 1) k = int'($urandom_range(0, pend_addr.size() - 1));
    end
    if (k >= 0) send_idx(k);
    else rd_rsp_valid = 1'b0;
    step();
    rd_rsp_valid = 1'b0;
  endtask

  task automatic send_tag(input int t);
    int k = -1;
    for (int i = 0; i < pend_tag.size(); i++) if (int'(pend_tag[i]) == t) k = i;
    if (k >= 0) send_idx(k);
    step();
    rd_rsp_valid = 1'b0;
  endtask

  task automatic start_job(input logic [ADDR_W-1:0] b, input logic [SIZE_W-1:0] n);
    req_addr_q.delete(); req_tag_q.delete();
    pend_addr.delete(); pend_tag.delete(); pend_cyc.delete();
    beat_q.delete(); last_q.delete();
    base_addr = b;
    num_lines = n;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic finish_job(input string name, input logic [ADDR_W-1:0] b, input int n);
    bit got_last = 1'b0;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] e;
    for (int i = 0; i < 4000 && !got_last; i++) begin
      int nb = beat_q.size();
      tick();
      if (beat_q.size() > nb && last_q[$]) got_last = 1'b1;
    end
    chk({name, "_completed"}, DATA_W'(got_last), 1);
    chk({name, "_done_next"}, DATA_W'(done), 1);
    chk({name, "_busy_clear"}, DATA_W'(busy), 0);
    chk({name, "_req_count"}, DATA_W'(req_addr_q.size()), DATA_W'(n));
    chk({name, "_beat_count"}, DATA_W'(beat_q.size()), DATA_W'(n));
    for (int i = 0; i < req_addr_q.size(); i++) begin
      a = b + ADDR_W'(i);
      chk({name, "_req_addr"}, DATA_W'(req_addr_q[i]), DATA_W'(a));
      chk({name, "_req_tag"}, DATA_W'(req_tag_q[i]), DATA_W'(i % DEPTH));
    end
    for (int i = 0; i < beat_q.size(); i++) begin
      a = b + ADDR_W'(i);
      e = mem.exists(a) ? mem[a] : '0;
      chk({name, "_beat_data"}, beat_q[i], e);
      chk({name, "_beat_last"}, DATA_W'(last_q[i]), DATA_W'(i == n - 1));
    end
  endtask

  task automatic chk_quiet(input string name);
    chk({name, "_req_valid"}, DATA_W'(rd_req_valid), 0);
    chk({name, "_req_addr"}, DATA_W'(rd_req_addr), 0);
    chk({name, "_req_mdata"}, DATA_W'(rd_req_mdata), 0);
    chk({name, "_out_valid"}, DATA_W'(out_valid), 0);
    chk({name, "_out_data"}, out_data, 0);
    chk({name, "_out_last"}, DATA_W'(out_last), 0);
    chk({name, "_busy"}, DATA_W'(busy), 0);
    chk({name, "_done"}, DATA_W'(done), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    reset = 1'b1; start = 1'b0; base_addr = '0; num_lines = '0;
    rd_req_almfull = 1'b0; rd_rsp_valid = 1'b0; rd_rsp_mdata = '0; rd_rsp_data = '0;
    out_ready = 1'b0; rsp_mode = 0; ready_mode = 0;
    almfull_viol = 0; stall_viol = 0; af_last = 1'b0; held = 1'b0; held_data = '0;
    repeat (3) tick();
    reset = 1'b0;
    chk_quiet("reset");

    // Basic in-order job with first-request latency check.
    rsp_mode = 0; ready_mode = 0;
    start_job(42'h1000, 4);
    chk("basic_no_early_req", DATA_W'(rd_req_valid), 0);
    chk("basic_busy", DATA_W'(busy), 1);
    tick();
    chk("basic_first_req", DATA_W'(rd_req_valid), 1);
    chk("basic_first_addr", DATA_W'(rd_req_addr), 42'h1000);
    finish_job("basic", 42'h1000, 4);

    // Reverse-order responses.
    rsp_mode = 2;
    start_job(42'h2000, 8);
    repeat (12) tick();
    chk("reorder_reqs", DATA_W'(req_addr_q.size()), 8);
    for (int t = 7; t >= 1; t--) send_tag(t);
    chk("reorder_wait_head", DATA_W'(out_valid), 0);
    send_tag(0);
    rsp_mode = 1;
    finish_job("reorder", 42'h2000, 8);

    // Credit limit.
    rsp_mode = 2;
    start_job(42'h40000, 100);
    repeat (60) tick();
    chk("credit_req_cap", DATA_W'(req_addr_q.size()), DEPTH);
    chk("credit_req_idle", DATA_W'(rd_req_valid), 0);
    send_tag(0);
    repeat (10) tick();
    chk("credit_one_more", DATA_W'(req_addr_q.size()), DEPTH + 1);
    chk("credit_one_beat", DATA_W'(beat_q.size()), 1);
    rsp_mode = 1; ready_mode = 1;
    finish_job("credit", 42'h40000, 100);

    // Almost-full window then ready toggling.
    rsp_mode = 1; ready_mode = 0; almfull_viol = 0; stall_viol = 0;
    start_job(42'h3_0000_0000, 40);
    repeat (4) tick();
    rd_req_almfull = 1'b1;
    tick();
    c0 = req_addr_q.size();
    repeat (4) tick();
    chk("almfull_no_issue", DATA_W'(req_addr_q.size()), DATA_W'(c0));
    rd_req_almfull = 1'b0;
    ready_mode = 2;
    finish_job("backpressure", 42'h3_0000_0000, 40);
    chk("almfull_violations", DATA_W'(almfull_viol), 0);
    chk("stall_violations", DATA_W'(stall_viol), 0);

    // Zero-length job.
    ready_mode = 0;
    start_job(42'h123, 0);
    tick();
    chk("zero_done", DATA_W'(done), 1);
    chk("zero_busy", DATA_W'(busy), 0);
    repeat (4) tick();
    chk("zero_no_req", DATA_W'(req_addr_q.size()), 0);
    chk("zero_no_out", DATA_W'(out_valid), 0);

    // Address wrap.
    rsp_mode = 1;
    start_job({ADDR_W{1'b1}} - 42'd1, 4);
    finish_job("wrap", {ADDR_W{1'b1}} - 42'd1, 4);
    if (req_addr_q.size() == 4) begin
      chk("wrap_addr2", DATA_W'(req_addr_q[2]), 0);
      chk("wrap_addr3", DATA_W'(req_addr_q[3]), 1);
    end

    // Reset mid-job, stale responses, then a fresh job.
    rsp_mode = 2;
    start_job(42'h5000, 20);
    for (int i = 0; i < 100 && req_addr_q.size() < 10; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    held = 1'b0;
    chk_quiet("midreset");
    for (int t = 0; t < 6; t++) send_tag(t);
    repeat (3) tick();
    chk_quiet("stale");
    rsp_mode = 0;
    start_job(42'h6000, 3);
    finish_job("after_reset", 42'h6000, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
